// File: rtl/falafel_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : falafel_mem_responder
// Brief   : Word-addressed memory model for the falafel LSU port; serves
//           read, write and CAS requests with a fixed response latency.
// Rev     : 1.0  initial release
// ============================================================================
module falafel_mem_responder #(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_req_val_i,
    output logic              mem_req_rdy_o,
    input  logic              mem_req_is_write_i,
    input  logic              mem_req_is_cas_i,
    input  logic [DATA_W-1:0] mem_req_addr_i,
    input  logic [DATA_W-1:0] mem_req_data_i,
    input  logic [DATA_W-1:0] mem_req_cas_exp_i,
    output logic              mem_rsp_val_o,
    input  logic              mem_rsp_rdy_i,
    output logic [DATA_W-1:0] mem_rsp_data_o,
    output logic [31:0]       cas_fail_cnt_o
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [31:0]         fail_cnt_q, fail_cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   old_word;
    logic                accept;
    logic                cas_hit;
    logic                wr_en;
    logic                addr_unused;

    assign idx         = mem_req_addr_i[OFF_W +: IDX_W];
    assign addr_unused = ^mem_req_addr_i;
    assign old_word    = mem_q[idx];

    assign mem_req_rdy_o  = (state_q == ST_IDLE) && !rst_i;
    assign mem_rsp_val_o  = (state_q == ST_RESP);
    assign mem_rsp_data_o = rsp_data_q;
    assign cas_fail_cnt_o = fail_cnt_q;

    assign accept  = mem_req_val_i && mem_req_rdy_o;
    assign cas_hit = (old_word == mem_req_cas_exp_i);
    // A failed CAS still answers with the old word but must not store.
    assign wr_en   = accept && mem_req_is_write_i && (!mem_req_is_cas_i || cas_hit);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        fail_cnt_d = fail_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d      = CNT_W'(LATENCY - 1);
                    rsp_data_d = (mem_req_is_write_i && !mem_req_is_cas_i) ? mem_req_data_i
                                                                            : old_word;
                    if (mem_req_is_write_i && mem_req_is_cas_i && !cas_hit
                        && (fail_cnt_q != 32'hFFFF_FFFF)) begin
                        fail_cnt_d = fail_cnt_q + 32'd1;
                    end
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem_rsp_rdy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[idx] <= mem_req_data_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_falafel_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_falafel_mem_responder
// Brief   : Directed self-checking bench; three responders at LATENCY 2, 1, 4.
// Rev     : 1.0  initial release
// ============================================================================
module tb_falafel_mem_responder;

    localparam int DATA_W = 64;
    localparam int LATS [3] = '{2, 1, 4};

    logic              clk;
    logic              rst;
    logic              val      [3];
    logic              rdy      [3];
    logic              rsp_val  [3];
    logic [DATA_W-1:0] rsp_data [3];
    logic [31:0]       fail_cnt [3];
    logic              is_write;
    logic              is_cas;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] cas_exp;
    logic              rsp_rdy;

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        falafel_mem_responder #(
            .DATA_W  (DATA_W),
            .DEPTH   (256),
            .LATENCY (LATS[g])
        ) u_dut (
            .clk_i              (clk),
            .rst_i              (rst),
            .mem_req_val_i      (val[g]),
            .mem_req_rdy_o      (rdy[g]),
            .mem_req_is_write_i (is_write),
            .mem_req_is_cas_i   (is_cas),
            .mem_req_addr_i     (addr),
            .mem_req_data_i     (wdata),
            .mem_req_cas_exp_i  (cas_exp),
            .mem_rsp_val_o      (rsp_val[g]),
            .mem_rsp_rdy_i      (rsp_rdy),
            .mem_rsp_data_o     (rsp_data[g]),
            .cas_fail_cnt_o     (fail_cnt[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction: issue, measure latency, optional backpressure, handshake.
    task automatic req(input int inst, input logic w, input logic c,
                       input logic [63:0] a, input logic [63:0] d, input logic [63:0] e,
                       input logic [63:0] exp_rsp, input int bp, input string tag);
        int lat;
        logic [63:0] held;
        @(negedge clk);
        is_write  = w;
        is_cas    = c;
        addr      = a;
        wdata     = d;
        cas_exp   = e;
        val[inst] = 1'b1;
        check({tag, "_rdy"}, 64'(rdy[inst]), 64'd1);
        @(posedge clk);
        #1;
        val[inst] = 1'b0;
        is_write  = 1'b0;
        is_cas    = 1'b0;
        addr      = '1;
        wdata     = '1;
        cas_exp   = '1;
        lat = 1;
        while (!rsp_val[inst] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(LATS[inst]));
        check({tag, "_data"}, rsp_data[inst], exp_rsp);
        held = rsp_data[inst];
        for (int k = 0; k < bp; k++) begin
            @(posedge clk);
            #1;
            check({tag, "_bp_val"}, 64'(rsp_val[inst]), 64'd1);
            check({tag, "_bp_data"}, rsp_data[inst], held);
            check({tag, "_bp_rdy"}, 64'(rdy[inst]), 64'd0);
        end
        rsp_rdy = 1'b1;
        @(posedge clk);
        #1;
        rsp_rdy = 1'b0;
        check({tag, "_post_rdy"}, 64'(rdy[inst]), 64'd1);
        check({tag, "_post_val"}, 64'(rsp_val[inst]), 64'd0);
    endtask

    initial begin
        bit seen;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        rsp_rdy  = 1'b0;
        is_write = 1'b0;
        is_cas   = 1'b0;
        addr     = '0;
        wdata    = '0;
        cas_exp  = '0;
        for (int i = 0; i < 3; i++) val[i] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", 64'(rdy[0]), 64'd0);
        check("rst_val", 64'(rsp_val[0]), 64'd0);
        check("rst_data", rsp_data[0], 64'd0);
        check("rst_cnt", 64'(fail_cnt[0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rdy_after_rst", 64'(rdy[0]), 64'd1);

        // LATENCY=2: write/read, CAS success and failure, read ignores is_cas
        req(0, 1, 0, 64'h40, 64'hDEAD_BEEF, 64'h0, 64'hDEAD_BEEF, 0, "wr40");
        req(0, 0, 0, 64'h40, 64'h0, 64'h0, 64'hDEAD_BEEF, 0, "rd40");
        req(0, 1, 0, 64'h08, 64'd5, 64'h0, 64'd5, 0, "wr08");
        req(0, 1, 1, 64'h08, 64'd9, 64'd5, 64'd5, 0, "cas_ok");
        check("cnt_after_ok", 64'(fail_cnt[0]), 64'd0);
        req(0, 0, 0, 64'h08, 64'h0, 64'h0, 64'd9, 0, "rd08_9");
        req(0, 1, 1, 64'h08, 64'd1, 64'd5, 64'd9, 0, "cas_fail");
        check("cnt_after_fail", 64'(fail_cnt[0]), 64'd1);
        req(0, 0, 1, 64'h08, 64'd7, 64'd9, 64'd9, 0, "rd08_still9");
        check("cnt_after_rdcas", 64'(fail_cnt[0]), 64'd1);
        req(0, 0, 0, 64'h40, 64'h0, 64'h0, 64'hDEAD_BEEF, 10, "bp");
        req(0, 1, 0, 64'h0800, 64'h11, 64'h0, 64'h11, 0, "wr_wrap");
        req(0, 0, 0, 64'h0003, 64'h0, 64'h0, 64'h11, 0, "rd_wrap");
        req(0, 0, 0, 64'h40, 64'h0, 64'h0, 64'hDEAD_BEEF, 0, "rd40_after_wrap");

        // LATENCY=1
        req(1, 1, 0, 64'h18, 64'h1234_5678_9ABC_DEF0, 64'h0, 64'h1234_5678_9ABC_DEF0, 0, "l1_wr");
        req(1, 0, 0, 64'h18, 64'h0, 64'h0, 64'h1234_5678_9ABC_DEF0, 0, "l1_rd");

        // LATENCY=4: reset while a read is in WAIT
        req(2, 1, 0, 64'h10, 64'hABC, 64'h0, 64'hABC, 0, "l4_wr");
        @(negedge clk);
        addr   = 64'h10;
        val[2] = 1'b1;
        @(posedge clk);
        #1;
        val[2] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_val", 64'(rsp_val[2]), 64'd0);
        check("midrst_rdy", 64'(rdy[2]), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_rdy_hold", 64'(rdy[2]), 64'd0);
        check("midrst_cnt", 64'(fail_cnt[0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rel_rdy", 64'(rdy[2]), 64'd1);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (rsp_val[2]) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("no_ghost_rsp", 64'(seen), 64'd0);
        req(2, 0, 0, 64'h10, 64'h0, 64'h0, 64'hABC, 0, "l4_rd_after_rst");
        req(0, 0, 0, 64'h40, 64'h0, 64'h0, 64'hDEAD_BEEF, 0, "rd40_after_rst");
        req(0, 0, 0, 64'h08, 64'h0, 64'h0, 64'd9, 0, "rd08_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/falafel_mem_responder.md
# falafel_mem_responder

Memory-side responder for the falafel LSU memory port: accepts read, write and compare-and-swap (CAS) requests over a valid/ready request channel and returns exactly one response per request over a valid/ready response channel. It owns a word-addressed storage array with configurable response latency. It is the other end of the interface the LSU drives, and serves as the memory model in unit and integration benches. One request is outstanding at a time, so every CAS is atomic by construction.

## Interface
- DATA_W, 64, word width; matches falafel_pkg DATA_W
- DEPTH, 256, number of DATA_W words stored; power of two, ≥ 2
- LATENCY, 2, cycles from the request-accept edge to the first cycle rsp_val is high; ≥ 1
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- mem_req_val_i  in  1  request valid
- mem_req_rdy_o  out  1  responder ready to accept a request
- mem_req_is_write_i  in  1  1 write/CAS, 0 read
- mem_req_is_cas_i  in  1  1 CAS (only when is_write=1), 0 plain write
- mem_req_addr_i  in  DATA_W  byte address
- mem_req_data_i  in  DATA_W  write data / CAS new value
- mem_req_cas_exp_i  in  DATA_W  CAS expected value
- mem_rsp_val_o  out  1  response valid
- mem_rsp_rdy_i  in  1  requester ready for the response
- mem_rsp_data_o  out  DATA_W  response data
- cas_fail_cnt_o  out  32  count of failed CAS operations, saturating

## Operation
- Word index = mem_req_addr_i[$clog2(DATA_W/8) +: $clog2(DEPTH)]; low byte-offset bits ignored; higher bits ignored, so addresses wrap modulo DEPTH words.
- Request decode at accept:
  - is_write=0: read. The response is the stored word. is_cas is ignored.
  - is_write=1, is_cas=0: write data to the word. The response is the written data.
  - is_write=1, is_cas=1: CAS. The response is always the old stored word.
    - If old == cas_exp, store data.
    - Otherwise leave the word unchanged and increment cas_fail_cnt_o, saturating at 2^32-1.
- The array access (read, compare, write) and the response-data capture all happen on the accept edge. The response register therefore holds pre-write contents for CAS, and requests are never reordered.
- FSM states:
  - IDLE: mem_req_rdy_o=1. On val&&rdy, perform the access, load the latency counter with LATENCY-1, then:
    - go to RESP if LATENCY=1;
    - otherwise go to WAIT.
  - WAIT: rdy=0, rsp_val=0. Decrement the counter each cycle; go to RESP when the counter reaches 0.
  - RESP: rsp_val=1, rdy=0. On rsp_val&&rsp_rdy, go to IDLE.
- Latency counter width is $clog2(LATENCY+1).
- The storage array is not cleared by reset. Its contents survive reset, and any write already performed at an accept edge persists.

## Timing
- Reset values: mem_req_rdy_o=0 while rst_i is high, mem_rsp_val_o=0, mem_rsp_data_o=0, cas_fail_cnt_o=0, FSM=IDLE.
- mem_req_rdy_o = (state==IDLE) && !rst_i. It goes high in the first cycle after rst_i falls.
- Accept occurs on the rising edge where mem_req_val_i && mem_req_rdy_o.
- mem_rsp_val_o is first high in the cycle starting LATENCY edges after the accept edge, e.g. LATENCY=1 gives the cycle immediately after accept.
- mem_rsp_val_o and mem_rsp_data_o hold stable until the handshake edge; backpressure may last indefinitely.
- After the response handshake edge, rdy is high in the next cycle. There is no same-cycle response/request turnaround.
- Minimum request spacing is LATENCY+1 cycles.
- Request inputs are sampled only at the accept edge. Changes while rdy=0 are ignored.
- Reset asserted mid-operation (WAIT or RESP): the in-flight response is dropped, rsp_val goes to 0 immediately, and no response is produced after reset.

## Test plan
- Write then read, LATENCY=2: write 0xDEAD_BEEF to addr 0x40, then read 0x40. Each rsp_val rises 2 cycles after accept; read response = 0xDEAD_BEEF; write response = 0xDEAD_BEEF.
- CAS success: word at 0x08 = 5; CAS exp=5 new=9 → response 5; a subsequent read returns 9; cas_fail_cnt_o stays 0.
- CAS failure: word at 0x08 = 9; CAS exp=5 new=1 → response 9; word stays 9; cas_fail_cnt_o=1.
- Backpressure: hold mem_rsp_rdy_i=0 for 10 cycles during a read response.
  - rsp_val and data are stable throughout and rdy stays 0.
  - Raising rsp_rdy completes the handshake and rdy is high the next cycle.
- Address wrap/offset, DEPTH=256: write 0x11 to addr 0x0800 (index 0), then read addr 0x0003 → 0x11.
- Reset mid-op: accept a read with LATENCY=4, assert rst_i in WAIT.
  - rsp_val never rises; rdy=0 during reset and 1 the cycle after release.
  - Memory contents written before reset are unchanged.
